seconds_bcd_timebase: RTL

Timebase and BCD seconds counter that drives the seven-segment seconds display path. Divides the system clock to a 1-per-second tick and keeps a two-digit BCD count 00–59. Sits directly upstream of the seven-segment decoder in the top-level user module, which consumes `ones_bcd`/`tens_bcd`. Adds run/pause, synchronous clear and an optional preset load.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seconds_bcd_timebase_tick_prescaler.sv | 37 +++
 rtl/seconds_bcd_timebase.sv | 117 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seconds display path: BCD digit limits and the
// packed seconds value {tens, ones} consumed by the seven-segment decoder.
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
    localparam logic [2:0] DIGIT_MAX_TENS = 3'd5;

    typedef struct packed {
        logic [2:0] tens;
        logic [3:0] ones;
    } bcd_sec_t;

    // True when both digits are inside the legal seconds range 00..59.
    function automatic logic bcd_sec_valid(input bcd_sec_t v);
        return (v.ones <= DIGIT_MAX_ONES) && (v.tens <= DIGIT_MAX_TENS);
    endfunction

endpackage

// File: rtl/seconds_bcd_timebase_tick_prescaler.sv
// ----------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-DIV counter used as the seconds timebase.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset (pcnt -> 0)
//   en          : count enable; when low pcnt is frozen, not cleared
//   sync_clr    : synchronous return of pcnt to 0 (wins over en)
//   wrap_strobe : combinational, high while en=1 and pcnt==DIV-1
// ----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic wrap_strobe
);

    localparam int             W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (sync_clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
        end
    end

    assign wrap_strobe = en && (pcnt == LAST);

endmodule

// File: rtl/seconds_bcd_timebase.sv
// ----------------------------------------------------------------------------
// seconds_bcd_timebase
// Divides clk down to TICK_HZ and keeps a BCD seconds count 00..59 for the
// seven-segment seconds display. Supports run/pause, synchronous clear and,
// when the macro SECONDS_LOAD_EN is defined, a validated preset load.
//   clk, rst  : clock, asynchronous active-high reset
//   run       : 1 = count, 0 = freeze prescaler and count
//   clear     : synchronous clear of prescaler and count (highest priority)
//   load      : preset strobe (SECONDS_LOAD_EN builds only)
//   load_val  : preset value, [6:4] tens BCD, [3:0] ones BCD
//   ones_bcd  : seconds ones digit 0..9 (registered)
//   tens_bcd  : seconds tens digit 0..5 (registered)
//   tick      : one-cycle pulse with every count advance
//   wrap      : one-cycle pulse with the tick of the 59 -> 00 step
//   load_err  : one-cycle pulse after a rejected (non-BCD / >59) load
// Without SECONDS_LOAD_EN, load/load_val are ignored and load_err stays 0.
// ----------------------------------------------------------------------------
module seconds_bcd_timebase
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [6:0] load_val,
    output logic [3:0] ones_bcd,
    output logic [2:0] tens_bcd,
    output logic       tick,
    output logic       wrap,
    output logic       load_err
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    if (DIV < 2) begin : g_div_check
        $error("seconds_bcd_timebase: CLK_HZ / TICK_HZ must be at least 2");
    end

    bcd_sec_t count;
    logic     load_act;
    logic     load_ok;
    logic     presc_en;
    logic     presc_clr;
    logic     adv;

`ifdef SECONDS_LOAD_EN
    assign load_act = load;
    assign load_ok  = bcd_sec_valid(bcd_sec_t'(load_val));
`else
    logic unused_load;
    assign load_act    = 1'b0;
    assign load_ok     = 1'b0;
    assign unused_load = ^{load, load_val};
`endif

    // A rejected load must leave pcnt untouched, so any active load (or a
    // clear) takes the prescaler out of counting for that edge.
    assign presc_en  = run & ~clear & ~load_act;
    assign presc_clr = clear | (load_act & load_ok);

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk         (clk),
        .rst         (rst),
        .en          (presc_en),
        .sync_clr    (presc_clr),
        .wrap_strobe (adv)
    );

    // BCD increment 00..59 with digit carry; never produces 10..15 in a digit.
    function automatic bcd_sec_t bcd_inc(input bcd_sec_t c);
        bcd_sec_t n;
        n = c;
        if (c.ones == DIGIT_MAX_ONES) begin
            n.ones = 4'd0;
            n.tens = (c.tens == DIGIT_MAX_TENS) ? 3'd0 : c.tens + 3'd1;
        end else begin
            n.ones = c.ones + 4'd1;
        end
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (load_act) begin
                if (load_ok) begin
                    count <= bcd_sec_t'(load_val);
                end else begin
                    load_err <= 1'b1;
                end
            end else if (adv) begin
                count <= bcd_inc(count);
                tick  <= 1'b1;
                wrap  <= (count.tens == DIGIT_MAX_TENS) && (count.ones == DIGIT_MAX_ONES);
            end
        end
    end

    assign ones_bcd = count.ones;
    assign tens_bcd = count.tens;

endmodule
